// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   ADDR_W_DEF      default address width
//   RESET_ADDR_DEF  default PC after reset
//   EXC_VECTOR_DEF  default exception vector
//   INSTR_BYTES_DEF default sequential increment
//   next_src_t      next-PC source select, also handy for debug/coverage
package fetch_pkg;

  localparam int          ADDR_W_DEF      = 32;
  localparam logic [31:0] RESET_ADDR_DEF  = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEF  = 32'h0000_0080;
  localparam int          INSTR_BYTES_DEF = 4;

  typedef enum logic [2:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_JMP,
    SRC_CALL,
    SRC_RET,
    SRC_EXC,
    SRC_HOLD
  } next_src_t;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack.
//   clk        clock, state updates on the falling edge
//   rst        synchronous active-high reset (pointer, count, overflow)
//   flush      empty the stack; overflow flag is kept
//   push/pop   push push_data / pop the top entry; both together replace
//              the top (or act as a plain push when empty)
//   top_data   entry that a pop would return
//   empty      no valid entries
//   count      number of valid entries
//   overflow   sticky, set when a push overwrites a valid entry
module return_stack #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_data,
  output logic [ADDR_W-1:0]        top_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int           PW   = $clog2(DEPTH);
  localparam logic [PW:0]  FULL = (PW+1)'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     ptr_dec;
  logic              replace;
  logic [PW-1:0]     waddr;

  assign ptr_dec  = ptr - PW'(1);
  assign top_data = mem[ptr_dec];
  assign empty    = (count == '0);
  // Pop+push on a non-empty stack swaps the top entry in place.
  assign replace  = push && pop && !empty;
  assign waddr    = replace ? ptr_dec : ptr;

  always_ff @(negedge clk) begin
    if (rst) begin
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      ptr      <= '0;
      count    <= '0;
    end else if (push) begin
      if (!replace) begin
        ptr <= ptr + PW'(1);
        // A full stack drops its oldest entry, which sits at ptr.
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + (PW+1)'(1);
      end
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - (PW+1)'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (!rst && !flush && push) mem[waddr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for instruction fetch.
//   Clk           clock, state updates on the falling edge
//   Reset         synchronous active-high reset
//   PCWrite       1 = advance/redirect, 0 = stall
//   Exception     redirect to EXC_VECTOR and flush the RAS (ignores stall)
//   BranchTaken   redirect to BranchTarget
//   Jump          redirect to JumpTarget
//   Call          push PCPlus, redirect to JumpTarget
//   Return        pop RAS (ReturnTarget when empty) and redirect there
//   PCResult      registered current PC
//   PCPlus        PCResult + INSTR_BYTES
//   RasCount      valid RAS entries
//   RasOverflow   sticky RAS overwrite flag
module pc_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = ADDR_W'(RESET_ADDR_DEF),
  parameter int                INSTR_BYTES = INSTR_BYTES_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR  = ADDR_W'(EXC_VECTOR_DEF),
  parameter int                RAS_DEPTH   = 4
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       PCWrite,
  input  logic                       Exception,
  input  logic                       BranchTaken,
  input  logic [ADDR_W-1:0]          BranchTarget,
  input  logic                       Jump,
  input  logic [ADDR_W-1:0]          JumpTarget,
  input  logic                       Call,
  input  logic                       Return,
  input  logic [ADDR_W-1:0]          ReturnTarget,
  output logic [ADDR_W-1:0]          PCResult,
  output logic [ADDR_W-1:0]          PCPlus,
  output logic [$clog2(RAS_DEPTH):0] RasCount,
  output logic                       RasOverflow
);

  next_src_t         next_src;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              ras_push;
  logic              ras_pop;
  logic              redirect_ok;

  assign PCPlus = PCResult + ADDR_W'(INSTR_BYTES);

  always_comb begin
    next_src = SRC_SEQ;
    if      (Exception)   next_src = SRC_EXC;
    else if (!PCWrite)    next_src = SRC_HOLD;
    else if (BranchTaken) next_src = SRC_BR;
    else if (Return)      next_src = SRC_RET;
    else if (Call)        next_src = SRC_CALL;
    else if (Jump)        next_src = SRC_JMP;
  end

  // Stack traffic only when the fetch actually advances and no branch wins.
  assign redirect_ok = PCWrite && !Exception && !BranchTaken;
  assign ras_push    = redirect_ok && Call;
  assign ras_pop     = redirect_ok && Return;

  always_comb begin
    pc_next = PCPlus;
    case (next_src)
      SRC_EXC:  pc_next = EXC_VECTOR;
      SRC_HOLD: pc_next = PCResult;
      SRC_BR:   pc_next = BranchTarget;
      SRC_RET:  pc_next = ras_empty ? ReturnTarget : ras_top;
      SRC_CALL: pc_next = JumpTarget;
      SRC_JMP:  pc_next = JumpTarget;
      default:  pc_next = PCPlus;
    endcase
  end

  always_ff @(negedge Clk) begin
    if (Reset) PCResult <= RESET_ADDR;
    else       PCResult <= pc_next;
  end

  return_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (Clk),
    .rst       (Reset),
    .flush     (Exception),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (PCPlus),
    .top_data  (ras_top),
    .empty     (ras_empty),
    .count     (RasCount),
    .overflow  (RasOverflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_pc_sequencer;

  localparam int DEPTH = 4;

  logic        Clk;
  logic        Reset;
  logic        PCWrite;
  logic        Exception;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Call;
  logic        Return;
  logic [31:0] ReturnTarget;
  logic [31:0] PCResult;
  logic [31:0] PCPlus;
  logic [2:0]  RasCount;
  logic        RasOverflow;

  pc_sequencer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PCWrite      (PCWrite),
    .Exception    (Exception),
    .BranchTaken  (BranchTaken),
    .BranchTarget (BranchTarget),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Call         (Call),
    .Return       (Return),
    .ReturnTarget (ReturnTarget),
    .PCResult     (PCResult),
    .PCPlus       (PCPlus),
    .RasCount     (RasCount),
    .RasOverflow  (RasOverflow)
  );

  initial Clk = 1'b1;
  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
  endfunction

  // Reference model: return addresses in a queue, newest at the back.
  logic [31:0] m_pc;
  logic [31:0] m_q[$];
  logic        m_ovf;
  bit          m_valid = 1'b0;

  function automatic void m_push(logic [31:0] v);
    m_q.push_back(v);
    if (m_q.size() > DEPTH) begin
      void'(m_q.pop_front());
      m_ovf = 1'b1;
    end
  endfunction

  function automatic void model_step();
    logic [31:0] r;
    if (Reset) begin
      m_pc = 32'h0; m_q.delete(); m_ovf = 1'b0; m_valid = 1'b1;
    end else if (Exception) begin
      m_pc = 32'h80; m_q.delete();
    end else if (!PCWrite) begin
      // stall
    end else if (BranchTaken) begin
      m_pc = BranchTarget;
    end else if (Return) begin
      r = (m_q.size() > 0) ? m_q.pop_back() : ReturnTarget;
      if (Call) m_push(m_pc + 32'd4);
      m_pc = r;
    end else if (Call) begin
      m_push(m_pc + 32'd4);
      m_pc = JumpTarget;
    end else if (Jump) begin
      m_pc = JumpTarget;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endfunction

  always @(posedge Clk) begin
    if (m_valid) begin
      chk("model_pc",     PCResult,          m_pc);
      chk("model_pcplus", PCPlus,            m_pc + 32'd4);
      chk("model_count",  32'(RasCount),     32'(m_q.size()));
      chk("model_ovf",    32'(RasOverflow),  32'(m_ovf));
    end
  end

  task automatic tick();
    @(negedge Clk);
    model_step();
    @(posedge Clk);
  endtask

  initial begin
    Reset = 1'b1; PCWrite = 1'b1; Exception = 1'b1; BranchTaken = 1'b0;
    BranchTarget = '0; Jump = 1'b0; JumpTarget = '0; Call = 1'b1;
    Return = 1'b0; ReturnTarget = '0;

    // Reset dominates Call and Exception
    tick(); tick();
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_cnt", 32'(RasCount), 32'd0);
    chk("rst_ovf", 32'(RasOverflow), 32'd0);
    Reset = 1'b0; Call = 1'b0; Exception = 1'b0;
    tick(); chk("seq_4", PCResult, 32'h4);
    tick(); chk("seq_8", PCResult, 32'h8);
    tick(); chk("seq_c", PCResult, 32'hC);
    tick(); chk("seq_10", PCResult, 32'h10);

    // Stall ignores branch; exception overrides stall
    PCWrite = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h40;
    repeat (3) tick();
    chk("stall_pc", PCResult, 32'h10);
    PCWrite = 1'b1;
    tick(); chk("branch_pc", PCResult, 32'h40);
    BranchTaken = 1'b0; PCWrite = 1'b0; Exception = 1'b1;
    tick(); chk("exc_stall_pc", PCResult, 32'h80);
    Exception = 1'b0; PCWrite = 1'b1;

    // Nested call/return
    Jump = 1'b1; JumpTarget = 32'h100;
    tick(); chk("jump_pc", PCResult, 32'h100);
    Jump = 1'b0; Call = 1'b1; JumpTarget = 32'h200;
    tick(); chk("call1_pc", PCResult, 32'h200);
    JumpTarget = 32'h300;
    tick(); chk("call2_pc", PCResult, 32'h300);
    chk("call2_cnt", 32'(RasCount), 32'd2);
    Call = 1'b0; Return = 1'b1;
    tick(); chk("ret1_pc", PCResult, 32'h204);
    tick(); chk("ret2_pc", PCResult, 32'h104);
    chk("ret2_cnt", 32'(RasCount), 32'd0);
    Return = 1'b0;

    // Overflow: five calls into a four-entry stack
    Jump = 1'b1; JumpTarget = 32'h0;
    tick();
    Jump = 1'b0; Call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      JumpTarget = 32'((i + 1) * 16);
      tick();
    end
    chk("ovf_pc", PCResult, 32'h50);
    chk("ovf_cnt", 32'(RasCount), 32'd4);
    chk("ovf_flag", 32'(RasOverflow), 32'd1);
    Call = 1'b0; Return = 1'b1;
    tick(); chk("pop_44", PCResult, 32'h44);
    tick(); chk("pop_34", PCResult, 32'h34);
    tick(); chk("pop_24", PCResult, 32'h24);
    tick(); chk("pop_14", PCResult, 32'h14);
    ReturnTarget = 32'h999;
    tick(); chk("pop_empty_pc", PCResult, 32'h999);
    chk("pop_empty_cnt", 32'(RasCount), 32'd0);
    Return = 1'b0;

    // Priority and simultaneous Return+Call
    Jump = 1'b1; JumpTarget = 32'h10;
    tick();
    Jump = 1'b0; Call = 1'b1; JumpTarget = 32'h50;
    tick(); chk("pre_pc", PCResult, 32'h50);
    Return = 1'b1; BranchTaken = 1'b1; BranchTarget = 32'h50;
    tick(); chk("brprio_pc", PCResult, 32'h50);
    chk("brprio_cnt", 32'(RasCount), 32'd1);
    BranchTaken = 1'b0; JumpTarget = 32'h700;
    tick(); chk("retcall_pc", PCResult, 32'h14);
    chk("retcall_cnt", 32'(RasCount), 32'd1);
    Call = 1'b0;
    tick(); chk("retcall_top", PCResult, 32'h54);
    Return = 1'b0;

    // Address wrap, then exception mid-stack
    Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
    tick(); chk("wrap_pcplus", PCPlus, 32'h0);
    Jump = 1'b0;
    tick(); chk("wrap_pc", PCResult, 32'h0);
    Call = 1'b1; JumpTarget = 32'h100;
    repeat (3) tick();
    chk("mid_cnt", 32'(RasCount), 32'd3);
    Call = 1'b0; Exception = 1'b1;
    tick(); chk("exc_pc", PCResult, 32'h80);
    chk("exc_cnt", 32'(RasCount), 32'd0);
    chk("exc_ovf_kept", 32'(RasOverflow), 32'd1);
    Exception = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
